// File: rtl/key_seq_ctrl_pkg.sv
// rtl/key_seq_ctrl_pkg.sv - shared types and ASCII constants for the key sequence cipher
package key_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_LOWER_A = 8'd97;
   localparam logic [7:0] ASCII_LOWER_Z = 8'd122;
   localparam logic [7:0] ALPHABET      = 8'd26;
   localparam logic [7:0] SPACE_CHAR    = 8'd32;

   function automatic logic is_lower(input logic [7:0] c);
      return (c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z);
   endfunction

endpackage

// File: rtl/key_seq_ctrl_shift_unit.sv
// rtl/key_seq_ctrl_shift_unit.sv - combinational alphabet shift of one lowercase letter by one key letter
module shift_unit
   import key_seq_ctrl_pkg::*;
(
   input  logic [7:0] ch_in,
   input  logic [7:0] key,
   input  logic       mode,
   output logic [7:0] ch_out
);

   logic [8:0] k;
   logic [8:0] sum;
   logic [8:0] diff;
   logic [8:0] res;

   // Nine-bit intermediates keep the sum and difference free of wrap-around.
   always_comb begin
      k    = {1'b0, key} - {1'b0, ASCII_LOWER_A};
      sum  = {1'b0, ch_in} + k;
      diff = {1'b0, ch_in} - k;
      if (mode == 1'b0) begin
         res = (sum > {1'b0, ASCII_LOWER_Z}) ? sum - {1'b0, ALPHABET} : sum;
      end else begin
         res = (diff < {1'b0, ASCII_LOWER_A}) ? diff + {1'b0, ALPHABET} : diff;
      end
      ch_out = 8'(res);
   end

endmodule

// File: rtl/key_seq_ctrl.sv
// rtl/key_seq_ctrl.sv - key entry FSM and one-stage registered shift cipher datapath
module key_seq_ctrl #(
   parameter int         KEY_SLOTS  = 4,
   parameter logic [7:0] SPACE_CHAR = key_seq_ctrl_pkg::SPACE_CHAR,
   localparam int        LEN_W      = $clog2(KEY_SLOTS + 1),
   localparam int        IDX_W      = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key_start,
   input  logic [7:0]             key_char,
   input  logic                   key_char_valid,
   input  logic                   key_done,
   input  logic                   mode,
   input  logic [7:0]             in_char,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [7:0]             out_char,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*KEY_SLOTS-1:0] key_arr,
   output logic [LEN_W-1:0]       key_len,
   output logic [IDX_W-1:0]       key_idx,
   output logic                   busy
);

   import key_seq_ctrl_pkg::*;

   state_t                 state_q, state_d;
   logic [8*KEY_SLOTS-1:0] key_arr_q, key_arr_d;
   logic [LEN_W-1:0]       key_len_q, key_len_d, len_upd;
   logic [IDX_W-1:0]       key_idx_q, key_idx_d;
   logic [7:0]             out_char_q, out_char_d;
   logic                   out_valid_q, out_valid_d;
   logic [7:0]             cur_key;
   logic [7:0]             shifted;
   logic                   accept;
   logic                   key_letter;

   assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   assign key_letter = key_char_valid && is_lower(key_char);

   always_comb begin
      cur_key = '0;
      for (int i = 0; i < KEY_SLOTS; i++) begin
         if (IDX_W'(i) == key_idx_q) begin
            cur_key = key_arr_q[8*i +: 8];
         end
      end
   end

   shift_unit u_shift (
      .ch_in  (in_char),
      .key    (cur_key),
      .mode   (mode),
      .ch_out (shifted)
   );

   always_comb begin
      state_d     = state_q;
      key_arr_d   = key_arr_q;
      key_len_d   = key_len_q;
      key_idx_d   = key_idx_q;
      out_char_d  = out_char_q;
      out_valid_d = out_valid_q;
      len_upd     = key_len_q + LEN_W'(key_letter);

      // The output register drains independently of the FSM so a pending
      // character survives a restart of key entry.
      if (accept) begin
         out_valid_d = 1'b1;
         if (is_lower(in_char)) begin
            out_char_d = shifted;
            if (LEN_W'(key_idx_q) + LEN_W'(1) == key_len_q) begin
               key_idx_d = '0;
            end else begin
               key_idx_d = key_idx_q + IDX_W'(1);
            end
         end else begin
            out_char_d = SPACE_CHAR;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         LOAD: begin
            if (key_letter) begin
               for (int i = 0; i < KEY_SLOTS; i++) begin
                  if (LEN_W'(i) == key_len_q) begin
                     key_arr_d[8*i +: 8] = key_char;
                  end
               end
               key_len_d = len_upd;
            end
            // A letter arriving with key_done counts toward the length test.
            if (len_upd == LEN_W'(KEY_SLOTS)) begin
               state_d = RUN;
            end else if (key_done) begin
               state_d = (len_upd != '0) ? RUN : IDLE;
            end
         end
         IDLE:    state_d = IDLE;
         RUN:     state_d = RUN;
         default: state_d = IDLE;
      endcase

      if (key_start) begin
         state_d   = LOAD;
         key_arr_d = '0;
         key_len_d = '0;
         key_idx_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         key_arr_q   <= '0;
         key_len_q   <= '0;
         key_idx_q   <= '0;
         out_char_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_arr_q   <= key_arr_d;
         key_len_q   <= key_len_d;
         key_idx_q   <= key_idx_d;
         out_char_q  <= out_char_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign key_arr   = key_arr_q;
   assign key_len   = key_len_q;
   assign key_idx   = key_idx_q;
   assign out_char  = out_char_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/key_seq_ctrl.md
KEY_SEQ_CTRL -- requirements
Module: key_seq_ctrl

Interface
REQ-001 SHALL have parameter KEY_SLOTS, default 4, maximum key length in characters; each character occupies 8 bits of key_arr.
REQ-002 SHALL have parameter SPACE_CHAR, default 8'd32, output substituted for non-lowercase input.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- key_start  in  1  one-cycle pulse; begins key entry.
- key_char  in  8  ASCII key character.
- key_char_valid  in  1  key_char valid this cycle.
- key_done  in  1  one-cycle pulse; ends key entry early.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on input accept.
- in_char  in  8  ASCII plaintext or ciphertext.
- in_valid  in  1  in_char valid.
- in_ready  out  1  block accepts in_char this cycle.
- out_char  out  8  result character.
- out_valid  out  1  out_char valid.
- out_ready  in  1  consumer accepts out_char.
- key_arr  out  32  stored key; byte 0 = first character.
- key_len  out  3  number of stored key characters, 0..4.
- key_idx  out  2  key slot applied to the next letter.
- busy  out  1  high when state is not IDLE.

Function
REQ-005 SHALL implement an FSM with states IDLE, LOAD and RUN.
REQ-006 From any state, key_start SHALL cause a transition to LOAD and clear key_len, key_idx and key_arr on that edge.
REQ-007 In LOAD, key_char_valid with key_char in 97..122 SHALL write key_char to byte key_len and increment key_len; any other key_char SHALL be ignored.
REQ-008 LOAD SHALL transition to RUN on the edge key_len reaches KEY_SLOTS.
REQ-009 In LOAD, key_done with key_len >= 1 SHALL transition to RUN; key_done with key_len = 0 SHALL transition to IDLE.
REQ-010 If key_done and a valid letter coincide, the letter SHALL be stored first and the length check SHALL use the updated key_len.
REQ-011 key_char_valid outside LOAD SHALL be ignored.
REQ-012 in_ready SHALL be (state == RUN) && (!out_valid || out_ready).
REQ-013 Accept SHALL occur when in_valid && in_ready; out_char and out_valid SHALL be registered on that edge, giving 1-cycle latency.
REQ-014 With k = key_arr byte key_idx minus 97 (range 0..25), the output SHALL be:
- Encrypt: in_char + k, minus 26 if the sum exceeds 122.
- Decrypt: in_char - k, plus 26 if the difference is below 97.
- Arithmetic SHALL use 9-bit intermediates so no wrap occurs.
REQ-015 An accepted in_char outside 97..122 SHALL produce SHALL produce SPACE_CHAR and SHALL leave key_idx unchanged.
REQ-016 An accepted letter SHALL advance key_idx, wrapping to 0 when key_idx + 1 == key_len.
REQ-017 out_valid SHALL stay high and out_char SHALL be held until out_valid && out_ready.
REQ-018 When out_ready is high and no new accept occurs, out_valid SHALL clear on that edge.
REQ-019 Simultaneous drain and accept SHALL keep out_valid high with the new out_char.
REQ-020 key_start while out_valid is pending SHALL not drop the pending output; it drains normally, and in_ready stays 0 until state returns to RUN.

Reset
REQ-021 While reset is high on a clock edge, the block SHALL enter:
- state IDLE, key_arr 0, key_len 0, key_idx 0;
- out_char 0, out_valid 0, in_ready 0, busy 0.
REQ-022 Reset SHALL dominate every other input, including mid-LOAD and mid-RUN, and pending output SHALL be discarded.

Structure
REQ-023 A shared package SHALL hold:
- the state enum (IDLE, LOAD, RUN);
- ASCII_LOWER_A = 97, ASCII_LOWER_Z = 122, ALPHABET = 26, SPACE_CHAR.
REQ-024 The shift arithmetic SHALL be a combinational sub-module, shift_unit (char, key, mode -> char); it SHALL be reusable by the cipher datapath.

Verification
REQ-025 The bench SHALL cover:
- Key entry: key_start, then "k","e","y", then key_done -> key_len = 3, key_arr = 0x79656B, state RUN.
- Encrypt "hello" (mode 0), out_ready = 1 -> outputs "rijvs", each 1 cycle after accept, key_idx 0,1,2,0,1,2.
- Decrypt "rijvs" with the same key (mode 1) -> outputs "hello".
- Key "bc", input "a b" -> outputs "b", 32, "d"; key_idx is unchanged across the space.
- 5 key chars "abcde" -> RUN after "d", key_len = 4, "e" ignored.
- out_ready = 0 for 3 cycles after an accept -> out_char held, in_ready = 0; out_ready = 1 -> drains.
- Reset asserted mid-RUN with out_valid = 1 -> next cycle out_valid = 0, key_len = 0, state IDLE.
